// File: rtl/ct_rtu_ptr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_rtu_ptr_pkg
// Description : Shared RTU pointer constants and types.
//               - ENTRY_NUM = 96 entries.
//               - PTR_WIDTH = 7-bit binary pointer.
// Revision    : 1.0 - initial release
// ============================================================================
package ct_rtu_ptr_pkg;

   localparam int ENTRY_NUM = 96;
   localparam int PTR_WIDTH = 7;

   typedef logic [PTR_WIDTH-1:0] ptr_t;
   typedef logic [ENTRY_NUM-1:0] expand_t;

endpackage : ct_rtu_ptr_pkg
`default_nettype wire

// File: rtl/ct_rtu_decode_96.sv
`default_nettype none
// ============================================================================
// Module      : ct_rtu_decode_96
// Description : Combinational 7-bit binary to 96-bit one-hot decoder.
//               Inputs of 96 or more decode to all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_rtu_decode_96
   import ct_rtu_ptr_pkg::*;
(
   input  logic [PTR_WIDTH-1:0] i_ptr,
   output logic [ENTRY_NUM-1:0] o_expand
);

   // One comparator per entry; out-of-range inputs match no entry.
   for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
      assign o_expand[i] = (i_ptr == PTR_WIDTH'(i));
   end

endmodule : ct_rtu_decode_96
`default_nettype wire

// File: rtl/ct_rtu_ptr_dec_96.sv
`default_nettype none
// ============================================================================
// Module      : ct_rtu_ptr_dec_96
// Description : 96-entry RTU circular pointer with wrap flag, held in binary
//               and decoded to one-hot for ptr, ptr+1 and ptr+2 (mod 96).
//               Supports advance by 0..3 and flush load (load wins over inc).
//               Optional sticky illegal-load flag is enabled by defining the
//               macro CT_RTU_PTR_ERR_CHK_EN; otherwise x_ptr_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_rtu_ptr_dec_96
   import ct_rtu_ptr_pkg::*;
#(
   parameter logic [PTR_WIDTH-1:0] RST_PTR = 7'd0
) (
   input  logic                 forever_cpuclk,
   input  logic                 cpurst,
   input  logic                 ptr_inc_vld,
   input  logic [1:0]           ptr_inc_num,
   input  logic                 ptr_load_vld,
   input  logic [PTR_WIDTH-1:0] ptr_load_val,
   input  logic                 ptr_load_flip,
   output logic [PTR_WIDTH-1:0] x_ptr,
   output logic                 x_ptr_flip,
   output logic [ENTRY_NUM-1:0] x_ptr0_expand,
   output logic [ENTRY_NUM-1:0] x_ptr1_expand,
   output logic [ENTRY_NUM-1:0] x_ptr2_expand,
   output logic                 x_ptr_err
);

   localparam logic [PTR_WIDTH:0]   c_ENTRY_SUM  = (PTR_WIDTH+1)'(ENTRY_NUM);
   localparam logic [PTR_WIDTH-1:0] c_LAST_ENTRY = PTR_WIDTH'(ENTRY_NUM - 1);

   // Modular add of a small offset (0..3) onto a legal pointer.
   function automatic ptr_t f_add_mod(input ptr_t ptr, input logic [1:0] num);
      logic [PTR_WIDTH:0] sum;
      sum = {1'b0, ptr} + {{(PTR_WIDTH-1){1'b0}}, num};
      if (sum >= c_ENTRY_SUM) begin
         return PTR_WIDTH'(sum - c_ENTRY_SUM);
      end
      return sum[PTR_WIDTH-1:0];
   endfunction

   ptr_t ptr_q, ptr_d;
   logic flip_q, flip_d;
   ptr_t w_inc_ptr;
   logic w_inc_wrap;
   logic w_load_ok;
   ptr_t w_ptr1;
   ptr_t w_ptr2;

   assign w_inc_ptr  = f_add_mod(ptr_q, ptr_inc_num);
   // The offset is far smaller than the ring, so a wrap is exactly a decrease.
   assign w_inc_wrap = (w_inc_ptr < ptr_q);
   assign w_load_ok  = (ptr_load_val <= c_LAST_ENTRY);
   assign w_ptr1     = f_add_mod(ptr_q, 2'd1);
   assign w_ptr2     = f_add_mod(ptr_q, 2'd2);

   // Next pointer/flip: load beats inc; illegal loads leave state untouched.
   always_comb begin
      ptr_d  = ptr_q;
      flip_d = flip_q;
      if (ptr_load_vld) begin
         if (w_load_ok) begin
            ptr_d  = ptr_load_val;
            flip_d = ptr_load_flip;
         end
      end else if (ptr_inc_vld) begin
         ptr_d  = w_inc_ptr;
         flip_d = flip_q ^ w_inc_wrap;
      end
   end

   // Pointer and wrap-flag registers with synchronous reset.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         ptr_q  <= RST_PTR;
         flip_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         flip_q <= flip_d;
      end
   end

`ifdef CT_RTU_PTR_ERR_CHK_EN
   logic err_q, err_d;

   // Sticky flag: any illegal load sets it until reset.
   always_comb begin
      err_d = err_q | (ptr_load_vld & ~w_load_ok);
   end

   // Error flag register with synchronous reset.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign x_ptr_err = err_q;
`else
   assign x_ptr_err = 1'b0;
`endif

   assign x_ptr      = ptr_q;
   assign x_ptr_flip = flip_q;

   ct_rtu_decode_96 u_dec_ptr0 (
      .i_ptr    (ptr_q),
      .o_expand (x_ptr0_expand)
   );

   ct_rtu_decode_96 u_dec_ptr1 (
      .i_ptr    (w_ptr1),
      .o_expand (x_ptr1_expand)
   );

   ct_rtu_decode_96 u_dec_ptr2 (
      .i_ptr    (w_ptr2),
      .o_expand (x_ptr2_expand)
   );

endmodule : ct_rtu_ptr_dec_96
`default_nettype wire

// File: tb/tb_ct_rtu_ptr_dec_96.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_rtu_ptr_dec_96
// Description : Self-checking bench for ct_rtu_ptr_dec_96 (RST_PTR = 0).
//               Expected state is queued when stimulus is applied and compared
//               after the following clock edge. Honours CT_RTU_PTR_ERR_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_rtu_ptr_dec_96;

   typedef struct {
      int          ptr;
      logic        flip;
      logic        err;
      logic [95:0] e0;
      logic [95:0] e1;
      logic [95:0] e2;
   } exp_t;

   logic        clk;
   logic        cpurst;
   logic        ptr_inc_vld;
   logic [1:0]  ptr_inc_num;
   logic        ptr_load_vld;
   logic [6:0]  ptr_load_val;
   logic        ptr_load_flip;
   logic [6:0]  x_ptr;
   logic        x_ptr_flip;
   logic [95:0] x_ptr0_expand;
   logic [95:0] x_ptr1_expand;
   logic [95:0] x_ptr2_expand;
   logic        x_ptr_err;

   exp_t exp_q[$];
   int   m_ptr;
   logic m_flip;
   logic m_err;
   int   n_chk;
   int   n_pass;

   ct_rtu_ptr_dec_96 #(.RST_PTR(7'd0)) u_dut (
      .forever_cpuclk (clk),
      .cpurst         (cpurst),
      .ptr_inc_vld    (ptr_inc_vld),
      .ptr_inc_num    (ptr_inc_num),
      .ptr_load_vld   (ptr_load_vld),
      .ptr_load_val   (ptr_load_val),
      .ptr_load_flip  (ptr_load_flip),
      .x_ptr          (x_ptr),
      .x_ptr_flip     (x_ptr_flip),
      .x_ptr0_expand  (x_ptr0_expand),
      .x_ptr1_expand  (x_ptr1_expand),
      .x_ptr2_expand  (x_ptr2_expand),
      .x_ptr_err      (x_ptr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] onehot(input int idx);
      logic [95:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Apply one cycle of stimulus, advance the reference model, queue result.
   task automatic step(input logic rst, input logic inc, input logic [1:0] num,
                       input logic ld, input logic [6:0] val, input logic lf);
      exp_t e;
      int   s;
      @(negedge clk);
      cpurst        = rst;
      ptr_inc_vld   = inc;
      ptr_inc_num   = num;
      ptr_load_vld  = ld;
      ptr_load_val  = val;
      ptr_load_flip = lf;
      if (rst) begin
         m_ptr  = 0;
         m_flip = 1'b0;
         m_err  = 1'b0;
      end else if (ld) begin
         if (int'(val) < 96) begin
            m_ptr  = int'(val);
            m_flip = lf;
         end else begin
`ifdef CT_RTU_PTR_ERR_CHK_EN
            m_err = 1'b1;
`endif
         end
      end else if (inc) begin
         s = m_ptr + int'(num);
         if (s >= 96) begin
            m_ptr  = s - 96;
            m_flip = ~m_flip;
         end else begin
            m_ptr = s;
         end
      end
      e.ptr  = m_ptr;
      e.flip = m_flip;
      e.err  = m_err;
      e.e0   = onehot(m_ptr);
      e.e1   = onehot((m_ptr + 1) % 96);
      e.e2   = onehot((m_ptr + 2) % 96);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare(tag_of(rst, inc, ld));
   endtask

   function automatic string tag_of(input logic rst, input logic inc, input logic ld);
      if (rst) return "rst";
      if (ld)  return "load";
      if (inc) return "inc";
      return "idle";
   endfunction

   task automatic compare(input string tag);
      exp_t e;
      chk({tag, "_qlen"}, 96'(exp_q.size() != 0), 96'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_ptr"},  96'(x_ptr),      96'(e.ptr));
         chk({tag, "_flip"}, 96'(x_ptr_flip), 96'(e.flip));
         chk({tag, "_err"},  96'(x_ptr_err),  96'(e.err));
         chk({tag, "_exp0"}, x_ptr0_expand,   e.e0);
         chk({tag, "_exp1"}, x_ptr1_expand,   e.e1);
         chk({tag, "_exp2"}, x_ptr2_expand,   e.e2);
         chk({tag, "_oh"},   96'($onehot(x_ptr0_expand) && $onehot(x_ptr1_expand)
                                 && $onehot(x_ptr2_expand)), 96'd1);
      end
   endtask

   initial begin
      n_chk         = 0;
      n_pass        = 0;
      m_ptr         = 0;
      m_flip        = 1'b0;
      m_err         = 1'b0;
      cpurst        = 1'b1;
      ptr_inc_vld   = 1'b0;
      ptr_inc_num   = 2'd0;
      ptr_load_vld  = 1'b0;
      ptr_load_val  = 7'd0;
      ptr_load_flip = 1'b0;

      // Reset state, with fixed values checked directly as well.
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_ptr0_lit", x_ptr0_expand, 96'h1);
      chk("rst_ptr1_lit", x_ptr1_expand, 96'h2);
      chk("rst_ptr2_lit", x_ptr2_expand, 96'h4);

      // Load 94 then inc by 3 wraps to 1 with flip set.
      step(0, 0, 0, 1, 7'd94, 0);
      step(0, 1, 3, 0, 0, 0);
      chk("wrap_ptr_lit",  96'(x_ptr), 96'd1);
      chk("wrap_flip_lit", 96'(x_ptr_flip), 96'd1);

      // Load beats inc in the same cycle.
      step(0, 0, 0, 1, 7'd50, 1);
      step(0, 1, 2, 1, 7'd10, 0);
      chk("prio_ptr_lit", 96'(x_ptr), 96'd10);

      // Illegal load leaves ptr; error flag sticks through legal ops.
      step(0, 0, 0, 1, 7'd20, 0);
      step(0, 0, 0, 1, 7'd100, 1);
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 1, 7'd5, 0);
      step(0, 0, 0, 1, 7'd96, 0);
      step(0, 0, 0, 1, 7'd127, 1);

      // Pointer 95: offsets wrap; inc by 1 reaches 0 and toggles flip.
      step(0, 0, 0, 1, 7'd95, 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);

      // Inc by zero holds.
      step(0, 1, 0, 0, 0, 0);

      // Reset together with inc by 3.
      step(0, 0, 0, 1, 7'd93, 1);
      step(1, 1, 3, 0, 0, 0);

      // Random stream.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
              2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
              7'($urandom_range(0, 127)), $urandom_range(0, 1) == 1);
      end

      chk("queue_drained", 96'(exp_q.size()), 96'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_ct_rtu_ptr_dec_96
`default_nettype wire
